// File: rtl/lighting_actuator.sv
// Lighting output driver: sequences lamp toggles with a fixed spacing to limit
// inrush, and steps the window-shade motor one level per period toward its target.
module lighting_actuator #(
    parameter int LAMP_GAP       = 4,
    parameter int SHADE_STEP_CYC = 8,
    parameter int SHADE_MAX      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] tgt_lightstate,
    input  logic [3:0]  tgt_wshade,
    output logic [15:0] lamp_out,
    output logic [4:0]  lamp_on_cnt,
    output logic [3:0]  shade_pos,
    output logic        shade_step,
    output logic        shade_dir,
    output logic        busy,
    output logic        done
);

    localparam int LCW = $clog2(LAMP_GAP + 1);
    localparam int SCW = $clog2(SHADE_STEP_CYC + 1);
    localparam logic [LCW-1:0] GAP_LAST  = LCW'(LAMP_GAP - 1);
    localparam logic [SCW-1:0] STEP_LAST = SCW'(SHADE_STEP_CYC - 1);
    localparam logic [3:0]     SMAX      = 4'(SHADE_MAX);

    typedef enum logic [1:0] {L_IDLE, L_RUN, L_WAIT} lamp_state_t;
    typedef enum logic       {S_IDLE, S_MOVE}        shade_state_t;

    typedef struct packed {
        logic [15:0] lamp;
        logic [3:0]  shade;
    } target_t;

    lamp_state_t    lamp_state;
    shade_state_t   shade_state;
    target_t        tgt;
    logic [LCW-1:0] gap_cnt;
    logic [SCW-1:0] step_cnt;

    logic           accept;
    logic [3:0]     shade_clamped;
    logic [15:0]    pend_off;
    logic [15:0]    pend_on;
    logic [15:0]    pend_sel;
    logic [15:0]    lamp_pick;
    logic [15:0]    lamp_toggled;
    logic           lamp_fin;
    logic [3:0]     pos_stepped;
    logic           shade_hit;
    logic           lamp_active_nxt;
    logic           shade_active_nxt;
    logic           busy_nxt;

    assign accept        = upd_valid & upd_ready;
    assign shade_clamped = ({1'b0, tgt_wshade} > 5'(SHADE_MAX)) ? SMAX : tgt_wshade;

    // Turn-offs drain before any turn-on so the lit count never overshoots.
    assign pend_off     = lamp_out & ~tgt.lamp;
    assign pend_on      = ~lamp_out & tgt.lamp;
    assign pend_sel     = (pend_off != 16'd0) ? pend_off : pend_on;
    assign lamp_pick    = pend_sel & (~pend_sel + 16'd1);
    assign lamp_toggled = lamp_out ^ lamp_pick;
    assign lamp_fin     = (lamp_state == L_RUN) && (lamp_toggled == tgt.lamp);

    assign pos_stepped  = shade_dir ? shade_pos + 4'd1 : shade_pos - 4'd1;
    assign shade_hit    = (shade_state == S_MOVE) && (step_cnt == STEP_LAST)
                          && (pos_stepped == tgt.shade);

    // Engines only ever start from idle, so on accept the next activity is
    // decided purely by whether the new targets differ from the present state.
    assign lamp_active_nxt  = accept ? (tgt_lightstate != lamp_out)
                                     : ((lamp_state != L_IDLE) && !lamp_fin);
    assign shade_active_nxt = accept ? (shade_clamped != shade_pos)
                                     : ((shade_state == S_MOVE) && !shade_hit);
    assign busy_nxt         = accept | lamp_active_nxt | shade_active_nxt;

    always_comb begin
        lamp_on_cnt = 5'd0;
        for (int i = 0; i < 16; i++)
            lamp_on_cnt = lamp_on_cnt + {4'd0, lamp_out[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamp_state  <= L_IDLE;
            shade_state <= S_IDLE;
            tgt         <= '0;
            gap_cnt     <= '0;
            step_cnt    <= '0;
            lamp_out    <= 16'd0;
            shade_pos   <= 4'd0;
            shade_step  <= 1'b0;
            shade_dir   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            upd_ready   <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            done       <= busy & ~busy_nxt;
            upd_ready  <= ~busy_nxt;
            shade_step <= 1'b0;

            if (accept) begin
                tgt.lamp   <= tgt_lightstate;
                tgt.shade  <= shade_clamped;
                gap_cnt    <= '0;
                step_cnt   <= '0;
                lamp_state <= (tgt_lightstate != lamp_out) ? L_RUN : L_IDLE;
                if (shade_clamped != shade_pos) begin
                    shade_state <= S_MOVE;
                    shade_dir   <= (shade_clamped > shade_pos);
                end else begin
                    shade_state <= S_IDLE;
                end
            end else begin
                case (lamp_state)
                    L_RUN: begin
                        lamp_out <= lamp_toggled;
                        if (lamp_fin)
                            lamp_state <= L_IDLE;
                        else if (LAMP_GAP == 1)
                            lamp_state <= L_RUN;
                        else begin
                            lamp_state <= L_WAIT;
                            gap_cnt    <= LCW'(1);
                        end
                    end
                    L_WAIT: begin
                        if (gap_cnt == GAP_LAST)
                            lamp_state <= L_RUN;
                        else
                            gap_cnt <= gap_cnt + LCW'(1);
                    end
                    default: lamp_state <= L_IDLE;
                endcase

                if (shade_state == S_MOVE) begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt   <= '0;
                        shade_step <= 1'b1;
                        shade_pos  <= pos_stepped;
                        if (pos_stepped == tgt.shade)
                            shade_state <= S_IDLE;
                    end else begin
                        step_cnt <= step_cnt + SCW'(1);
                    end
                end
            end
        end
    end

endmodule
